demux8_pack: RTL

- Write-side counterpart of the 8-way operand selector in the multi-cycle CPU datapath.
- Accepts one WIDTH-bit word per cycle with a 3-bit destination select and writes it into one of 8 holding slots.
- Presents all slots on a packed 8*WIDTH bus, in exactly the slot layout the 8-to-1 selector consumes.
- Tracks per-slot occupancy so the control FSM can gather operands over several cycles, then consume them.

---
 rtl/demux8_pack_pkg.sv | 12 +
 rtl/demux8_slot.sv | 39 +++
 rtl/demux8_pack.sv | 74 +++++++
 3 files changed

// File: rtl/demux8_pack_pkg.sv
// Shared CPU datapath constants and the packing rule for the 8-way operand bus.
// The 8-to-1 selector uses slot_lsb too, so both ends agree on the slot layout.
package demux8_pack_pkg;

    localparam int SLOT_COUNT = 8;
    localparam int SEL_W      = 3;

    function automatic int slot_lsb(input int i, input int width);
        return i * width;
    endfunction

endpackage

// File: rtl/demux8_slot.sv
// One holding slot: data register plus its occupancy flag.
// The write wins over a clear that arrives on the same edge.
module demux8_slot #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o,
    output logic             v_o,
    output logic             v_next_o
);

    logic [WIDTH-1:0] q_q;
    logic             v_q;
    logic             v_d;

    // Clearing only drops occupancy; the data bits stay on the bus.
    assign v_d = wr_en_i | (v_q & ~clr_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
            v_q <= 1'b0;
        end else begin
            if (wr_en_i) begin
                q_q <= d_i;
            end
            v_q <= v_d;
        end
    end

    assign q_o      = q_q;
    assign v_o      = v_q;
    assign v_next_o = v_d;

endmodule

// File: rtl/demux8_pack.sv
// Write-side 1-to-8 demux feeding the packed operand bus of the 8-to-1 selector,
// with per-slot occupancy so the control FSM can gather operands over several cycles.
module demux8_pack
    import demux8_pack_pkg::*;
#(
    parameter int WIDTH     = 1,
    parameter bit OVERWRITE = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_data,
    input  logic [SEL_W-1:0]        select,
    input  logic [SLOT_COUNT-1:0]   clr,
    output logic [SLOT_COUNT*WIDTH-1:0] out,
    output logic [SLOT_COUNT-1:0]   slot_valid,
    output logic                    all_valid,
    output logic [3:0]              count
);

    logic                  accept;
    logic [SLOT_COUNT-1:0] wr_en;
    logic [SLOT_COUNT-1:0] v_next;
    logic [3:0]            count_d;
    logic [3:0]            count_q;
    logic                  all_valid_d;
    logic                  all_valid_q;

    assign in_ready = OVERWRITE | ~slot_valid[select];
    // in_valid gates the decode so an undriven select cannot reach any slot.
    assign accept   = in_valid & in_ready;

    genvar gi;
    generate
        for (gi = 0; gi < SLOT_COUNT; gi++) begin : g_slot
            assign wr_en[gi] = accept & (select == SEL_W'(gi));

            demux8_slot #(.WIDTH(WIDTH)) u_slot (
                .clk      (clk),
                .rst_n    (rst_n),
                .wr_en_i  (wr_en[gi]),
                .clr_i    (clr[gi]),
                .d_i      (in_data),
                .q_o      (out[slot_lsb(gi, WIDTH) +: WIDTH]),
                .v_o      (slot_valid[gi]),
                .v_next_o (v_next[gi])
            );
        end
    endgenerate

    // Derived from next occupancy so count and all_valid track slot_valid exactly.
    always_comb begin
        count_d = '0;
        for (int i = 0; i < SLOT_COUNT; i++) begin
            count_d = count_d + 4'(v_next[i]);
        end
        all_valid_d = &v_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= '0;
            all_valid_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            all_valid_q <= all_valid_d;
        end
    end

    assign count     = count_q;
    assign all_valid = all_valid_q;

endmodule
